// File: rtl/codificador_arbiter_pkg.sv
// codificador_pkg: shared types and constants for the Codificador arbiter slice.
//   state_t   : arbiter FSM states (IDLE, CLEAR, LOAD, RESP)
//   CODE_W    : width of one requester nibble / encoder code
//   SETTLE_W  : width of the LOAD settle counter (SETTLE up to 15)
package codificador_pkg;

    localparam int CODE_W   = 4;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/codificador_arbiter_if.sv
// codificador_arbiter_if: requester-side and encoder-side signals of the arbiter.
//   req/req_data          : per-requester request level and nibble ([4i+3:4i])
//   gnt                   : one-hot grant pulse
//   rsp_valid/id/code     : response pulse, requester index, captured {S0,S1,S2,S3}
//   busy                  : arbiter not in IDLE
//   enc_a..d/ready/reset  : drive the shared Codificador
//   enc_s                 : Codificador outputs {S0,S1,S2,S3}
// Modports: master = arbiter side, slave = requesters plus encoder side.
interface codificador_arbiter_if
    import codificador_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [CODE_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [CODE_W-1:0]       rsp_code;
    logic                    busy;
    logic                    enc_a;
    logic                    enc_b;
    logic                    enc_c;
    logic                    enc_d;
    logic                    enc_ready;
    logic                    enc_reset;
    logic [CODE_W-1:0]       enc_s;

    modport master (
        input  req, req_data, enc_s,
        output gnt, rsp_valid, rsp_id, rsp_code, busy,
               enc_a, enc_b, enc_c, enc_d, enc_ready, enc_reset
    );

    modport slave (
        output req, req_data, enc_s,
        input  gnt, rsp_valid, rsp_id, rsp_code, busy,
               enc_a, enc_b, enc_c, enc_d, enc_ready, enc_reset
    );

endinterface

// File: rtl/Codificador.sv
// Codificador: combinational 4-bit encoder shared by the arbiter.
//   A..D  in  : data nibble, A is the most significant bit
//   reset in  : active-high clear, forces all outputs low
//   ready in  : outputs are valid only while ready is high
//   S0..S3 out: Gray code of {A,B,C,D}, S0 most significant
module Codificador (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic reset,
    input  logic ready,
    output logic S0,
    output logic S1,
    output logic S2,
    output logic S3
);

    // Binary-to-Gray conversion, held at zero while cleared or not ready.
    always_comb begin
        S0 = 1'b0;
        S1 = 1'b0;
        S2 = 1'b0;
        S3 = 1'b0;
        if (!reset && ready) begin
            S0 = A;
            S1 = A ^ B;
            S2 = B ^ C;
            S3 = C ^ D;
        end
    end

endmodule

// File: rtl/codificador_arbiter_rr_pick.sv
// codificador_rr_pick: combinational rotate-priority picker.
//   i_req     : request vector
//   i_ptr     : index granted last; search starts at i_ptr+1 and wraps
//   o_onehot  : one-hot winner
//   o_idx     : winner index
//   o_valid   : at least one request present
module codificador_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_valid
);

    // Two passes replace a modulo rotate: first the indices above the
    // pointer, then from 0 upward, which covers the wrapped part.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_valid && (i > int'(i_ptr)) && i_req[i]) begin
                o_valid     = 1'b1;
                o_idx       = ID_W'(i);
                o_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_valid && i_req[i]) begin
                o_valid     = 1'b1;
                o_idx       = ID_W'(i);
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/codificador_arbiter.sv
// codificador_arbiter: shares one Codificador among N_REQ requesters.
// Each grant runs CLEAR (encoder reset), SETTLE LOAD cycles (encoder ready),
// captures the encoder output and answers the requester in RESP.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : codificador_arbiter_if.master (requester and encoder signals)
// Parameters: N_REQ (2..16), SETTLE (1..15).
// Macro CODIFICADOR_ARB_FIXED_PRIO_EN: lowest index always wins, no RR pointer.
module codificador_arbiter
    import codificador_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset_n,
    codificador_arbiter_if.master bus
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [SETTLE_W-1:0] LAST_LOAD = SETTLE_W'(SETTLE - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [ID_W-1:0]     r_idQ;
    logic [ID_W-1:0]     r_rspId;
    logic [ID_W-1:0]     w_ptr;
    logic [ID_W-1:0]     w_pickIdx;
    logic [N_REQ-1:0]    r_gntVec;
    logic [N_REQ-1:0]    w_pickOnehot;
    logic                w_pickValid;
    logic                w_grant;
    logic                w_lastLoad;
    logic [CODE_W-1:0]   r_dataQ;
    logic [CODE_W-1:0]   r_rspCode;
    logic [CODE_W-1:0]   w_pickData;
    logic [SETTLE_W-1:0] r_cnt;

`ifdef CODIFICADOR_ARB_FIXED_PRIO_EN
    assign w_ptr = ID_W'(N_REQ - 1);
`else
    logic [ID_W-1:0] r_ptr;

    // Round-robin pointer remembers the last granted index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= ID_W'(N_REQ - 1);
        end else if (w_grant) begin
            r_ptr <= w_pickIdx;
        end
    end

    assign w_ptr = r_ptr;
`endif

    codificador_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (w_ptr),
        .o_onehot (w_pickOnehot),
        .o_idx    (w_pickIdx),
        .o_valid  (w_pickValid)
    );

    // Select the winner's nibble from the packed request data.
    always_comb begin
        w_pickData = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pickOnehot[i]) begin
                w_pickData = bus.req_data[i*CODE_W +: CODE_W];
            end
        end
    end

    // A grant can only start from IDLE or straight out of RESP.
    assign w_grant    = ((r_state == IDLE) || (r_state == RESP)) && w_pickValid;
    assign w_lastLoad = (r_state == LOAD) && (r_cnt == LAST_LOAD);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = w_pickValid ? CLEAR : IDLE;
            CLEAR:   w_nextState = LOAD;
            LOAD:    w_nextState = w_lastLoad ? RESP : LOAD;
            RESP:    w_nextState = w_pickValid ? CLEAR : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode; the encoder is held in reset whenever it is not loading
    // or being read back, including during the asynchronous reset.
    always_comb begin
        bus.gnt       = '0;
        bus.busy      = 1'b1;
        bus.enc_reset = 1'b1;
        bus.enc_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.busy = 1'b0;
            end
            CLEAR: begin
                bus.gnt = r_gntVec;
            end
            LOAD: begin
                bus.enc_reset = 1'b0;
                bus.enc_ready = 1'b1;
            end
            RESP: begin
                bus.enc_reset = 1'b0;
                bus.rsp_valid = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    // LOAD cycle counter, idle at zero outside LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if ((r_state == LOAD) && !w_lastLoad) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Transaction registers: winner latched on grant, code captured at the
    // end of the last LOAD cycle and held until the next capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idQ     <= '0;
            r_gntVec  <= '0;
            r_dataQ   <= '0;
            r_rspCode <= '0;
            r_rspId   <= '0;
        end else begin
            if (w_grant) begin
                r_idQ    <= w_pickIdx;
                r_gntVec <= w_pickOnehot;
                r_dataQ  <= w_pickData;
            end
            if (w_lastLoad) begin
                r_rspCode <= bus.enc_s;
                r_rspId   <= r_idQ;
            end
        end
    end

    assign bus.rsp_id   = r_rspId;
    assign bus.rsp_code = r_rspCode;
    assign {bus.enc_a, bus.enc_b, bus.enc_c, bus.enc_d} = r_dataQ;

endmodule

// File: tb/tb_codificador_arbiter.sv
// tb_codificador_arbiter: two arbiter instances (SETTLE=1 and SETTLE=3), each
// driving a real Codificador, checked every cycle against a transaction-level
// model plus directed literal expectations.
module tb_codificador_arbiter;

    localparam int NREQ = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  tbReq  [2];
    logic [15:0] tbData [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Single comparison point shared by the per-cycle model check and the
    // directed checks.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Arbitration rule: search from last+1 with wrap, or lowest index first.
    function automatic int pickWinner(input logic [3:0] r, input int last);
        int w;
        int start;
        w     = -1;
        start = last;
`ifdef CODIFICADOR_ARB_FIXED_PRIO_EN
        start = NREQ - 1;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (start + k) % NREQ;
            if (w < 0 && r[c]) w = c;
        end
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int SET = (g == 0) ? 1 : 3;

        codificador_arbiter_if #(.N_REQ(NREQ)) bus ();

        logic [3:0] encS;
        logic [3:0] refS;
        logic [3:0] mNib     = 4'h0;
        logic [3:0] mRspCode = 4'h0;
        logic [3:0] mEnc     = 4'h0;
        int         pos      = 0;
        int         mId      = 0;
        int         mLast    = NREQ - 1;
        int         mRspId   = 0;

        assign bus.req      = tbReq[g];
        assign bus.req_data = tbData[g];
        assign bus.enc_s    = encS;

        codificador_arbiter #(.N_REQ(NREQ), .SETTLE(SET)) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
        );

        Codificador uEnc (
            .A(bus.enc_a), .B(bus.enc_b), .C(bus.enc_c), .D(bus.enc_d),
            .reset(bus.enc_reset), .ready(bus.enc_ready),
            .S0(encS[3]), .S1(encS[2]), .S2(encS[1]), .S3(encS[0])
        );

        Codificador uRef (
            .A(mNib[3]), .B(mNib[2]), .C(mNib[1]), .D(mNib[0]),
            .reset(1'b0), .ready(1'b1),
            .S0(refS[3]), .S1(refS[2]), .S2(refS[1]), .S3(refS[0])
        );

        // Model: pos counts cycles into the transaction (1 = grant cycle,
        // SET+2 = response cycle), 0 when nothing is in flight.
        always @(posedge clk or negedge reset_n) begin
            int w;
            if (!reset_n) begin
                pos      = 0;
                mLast    = NREQ - 1;
                mRspId   = 0;
                mRspCode = 4'h0;
                mEnc     = 4'h0;
            end else if (pos >= 1 && pos <= SET + 1) begin
                if (pos == SET + 1) begin
                    mRspId   = mId;
                    mRspCode = refS;
                end
                pos++;
            end else begin
                w = pickWinner(tbReq[g], mLast);
                if (w >= 0) begin
                    mId   = w;
                    mLast = w;
                    mNib  = tbData[g][w*4 +: 4];
                    mEnc  = mNib;
                    pos   = 1;
                end else begin
                    pos = 0;
                end
            end
        end

        // Per-cycle comparison against the model.
        always @(negedge clk) begin
            checkOutput($sformatf("i%0d.gnt", g), 32'(bus.gnt), (pos == 1) ? (32'd1 << mId) : 32'd0);
            checkOutput($sformatf("i%0d.busy", g), 32'(bus.busy), 32'(pos != 0));
            checkOutput($sformatf("i%0d.enc_reset", g), 32'(bus.enc_reset), 32'(pos <= 1));
            checkOutput($sformatf("i%0d.enc_ready", g), 32'(bus.enc_ready), 32'(pos >= 2 && pos <= SET + 1));
            checkOutput($sformatf("i%0d.enc_data", g), 32'({bus.enc_a, bus.enc_b, bus.enc_c, bus.enc_d}), 32'(mEnc));
            checkOutput($sformatf("i%0d.rsp_valid", g), 32'(bus.rsp_valid), 32'(pos == SET + 2));
            checkOutput($sformatf("i%0d.rsp_id", g), 32'(bus.rsp_id), 32'(mRspId));
            checkOutput($sformatf("i%0d.rsp_code", g), 32'(bus.rsp_code), 32'(mRspCode));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int inst, input logic [3:0] r, input logic [15:0] d);
        tbReq[inst]  = r;
        tbData[inst] = d;
    endtask

    initial begin
        logic [3:0] grayTab [16];
        int         expOrder [5];
        int         gotIdx [5];
        int         gotCyc [5];
        int         nG;
        int         lastG;
        int         lat;
        logic [3:0] code;
        bit         dropped;

        grayTab  = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
`ifdef CODIFICADOR_ARB_FIXED_PRIO_EN
        expOrder = '{0, 0, 0, 0, 0};
`else
        expOrder = '{0, 1, 2, 3, 0};
`endif
        applyStimulus(0, 4'b0000, 16'h0000);
        applyStimulus(1, 4'b0000, 16'h0000);

        // Reset values.
        step(1);
        checkOutput("reset.enc_reset", 32'(gInst[0].bus.enc_reset), 1);
        checkOutput("reset.busy", 32'(gInst[0].bus.busy), 0);
        checkOutput("reset.gnt", 32'(gInst[0].bus.gnt), 0);
        checkOutput("reset.rsp_code", 32'(gInst[1].bus.rsp_code), 0);
        step(1);
        reset_n = 1'b1;
        step(1);

        // Single request from requester 1, nibble 0101, SETTLE=1.
        applyStimulus(0, 4'b0010, 16'h0050);
        step(1);
        checkOutput("single.gnt", 32'(gInst[0].bus.gnt), 'h2);
        checkOutput("single.enc_reset", 32'(gInst[0].bus.enc_reset), 1);
        checkOutput("single.enc_ready_c1", 32'(gInst[0].bus.enc_ready), 0);
        applyStimulus(0, 4'b0000, 16'h0000);
        step(1);
        checkOutput("single.enc_data", 32'({gInst[0].bus.enc_a, gInst[0].bus.enc_b,
                    gInst[0].bus.enc_c, gInst[0].bus.enc_d}), 'h5);
        checkOutput("single.enc_ready_c2", 32'(gInst[0].bus.enc_ready), 1);
        step(1);
        checkOutput("single.rsp_valid", 32'(gInst[0].bus.rsp_valid), 1);
        checkOutput("single.rsp_id", 32'(gInst[0].bus.rsp_id), 1);
        checkOutput("single.rsp_code", 32'(gInst[0].bus.rsp_code), 'h7);
        step(1);

        // Reset during LOAD on the SETTLE=3 instance.
        applyStimulus(1, 4'b0100, 16'h0900);
        step(1);
        checkOutput("rst.gnt", 32'(gInst[1].bus.gnt), 'h4);
        applyStimulus(1, 4'b0000, 16'h0000);
        step(1);
        checkOutput("rst.in_load", 32'(gInst[1].bus.enc_ready), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst.busy", 32'(gInst[1].bus.busy), 0);
        checkOutput("rst.enc_reset", 32'(gInst[1].bus.enc_reset), 1);
        checkOutput("rst.enc_ready", 32'(gInst[1].bus.enc_ready), 0);
        checkOutput("rst.enc_data", 32'({gInst[1].bus.enc_a, gInst[1].bus.enc_b,
                    gInst[1].bus.enc_c, gInst[1].bus.enc_d}), 0);
        step(2);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            checkOutput("rst.no_rsp", 32'(gInst[1].bus.rsp_valid), 0);
        end

        // All four requesters held high on the SETTLE=1 instance.
        applyStimulus(0, 4'b1111, 16'h4321);
        nG    = 0;
        lastG = -1;
        for (int cyc = 1; cyc <= 30 && nG < 5; cyc++) begin
            step(1);
            if (gInst[0].bus.rsp_valid) begin
                checkOutput("rr.rsp_id", 32'(gInst[0].bus.rsp_id), 32'(lastG));
            end
            if (gInst[0].bus.gnt != 4'b0000) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gInst[0].bus.gnt[i]) gotIdx[nG] = i;
                end
                gotCyc[nG] = cyc;
                lastG      = gotIdx[nG];
                nG++;
            end
        end
        applyStimulus(0, 4'b0000, 16'h0000);
        checkOutput("rr.count", 32'(nG), 5);
        for (int i = 0; i < nG; i++) begin
            checkOutput($sformatf("rr.grant%0d", i), 32'(gotIdx[i]), 32'(expOrder[i]));
            if (i == 0) checkOutput("rr.first_cycle", 32'(gotCyc[0]), 1);
            else checkOutput($sformatf("rr.spacing%0d", i), 32'(gotCyc[i] - gotCyc[i-1]), 3);
        end
        step(4);

        // Requester 3 drops req and changes data right after its grant.
        applyStimulus(0, 4'b1000, 16'hA000);
        step(1);
        checkOutput("drop.gnt", 32'(gInst[0].bus.gnt), 'h8);
        applyStimulus(0, 4'b0000, 16'h5000);
        step(2);
        checkOutput("drop.rsp_valid", 32'(gInst[0].bus.rsp_valid), 1);
        checkOutput("drop.rsp_id", 32'(gInst[0].bus.rsp_id), 3);
        checkOutput("drop.rsp_code", 32'(gInst[0].bus.rsp_code), 'hF);
        step(1);

        // Sweep all nibbles through requester 2 on the SETTLE=3 instance.
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1, 4'b0100, 16'(n << 8));
            lat     = -1;
            code    = 4'h0;
            dropped = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                step(1);
                if (!dropped && gInst[1].bus.gnt[2]) begin
                    applyStimulus(1, 4'b0000, 16'h0000);
                    dropped = 1'b1;
                end
                if (gInst[1].bus.rsp_valid) begin
                    lat  = k;
                    code = gInst[1].bus.rsp_code;
                    break;
                end
            end
            checkOutput($sformatf("sweep%0d.latency", n), 32'(lat), 5);
            checkOutput($sformatf("sweep%0d.code", n), 32'(code), 32'(grayTab[n]));
        end
        applyStimulus(1, 4'b0000, 16'h0000);
        step(2);

        // Idle bus.
        for (int k = 0; k < 20; k++) begin
            step(1);
            checkOutput("idle.busy", 32'(gInst[0].bus.busy), 0);
            checkOutput("idle.gnt", 32'(gInst[0].bus.gnt), 0);
            checkOutput("idle.rsp_valid", 32'(gInst[0].bus.rsp_valid), 0);
            checkOutput("idle.busy1", 32'(gInst[1].bus.busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
